// File: rtl/mic_sample_fifo_if.sv
// Sample stream from mic_sample_fifo to its consumer.
// A word transfers on a rising clk edge where m_valid and m_ready are both 1; m_data holds while m_valid=1 and m_ready=0.
interface mic_sample_fifo_if;
    logic [11:0] m_data;
    logic        m_valid;
    logic        m_ready;

    modport master (output m_data, output m_valid, input m_ready);
    modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/mic_sample_fifo.sv
// Periodic microphone sampler: a divided-clock tick requests one conversion from an
// SPI mic reader and the returned 12-bit sample is queued in a first-word-fall-through FIFO.
module mic_sample_fifo #(
    parameter int CLK_DIV    = 2268,
    parameter int TIMEOUT    = 1023,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run,
    output logic                  mic_en,
    input  logic [11:0]           mic_data,
    input  logic                  mic_read_data,
    mic_sample_fifo_if.master     m,
    output logic [DEPTH_LOG2:0]   count,
    output logic [2:0]            status,
    input  logic                  clear_status,
    output logic [1:0]            dbg_state
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_TICK = 2'd1,
        REQUEST   = 2'd2,
        WAIT_DATA = 2'd3
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [15:0]           timer_q;
    logic                  tick;
    logic [9:0]            wait_q;
    logic                  push_try;
    logic                  timeout_hit;
    logic                  missed_tick;
    logic [11:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  full;
    logic                  pop;
    logic                  push;
    logic                  overflow;

    assign tick        = run && (timer_q == 16'(CLK_DIV - 1));
    assign missed_tick = tick && (state_q != WAIT_TICK);

    always_comb begin
        state_d     = state_q;
        mic_en      = 1'b0;
        push_try    = 1'b0;
        timeout_hit = 1'b0;
        case (state_q)
            IDLE: begin
                if (run) state_d = WAIT_TICK;
            end
            WAIT_TICK: begin
                if (tick)      state_d = REQUEST;
                else if (!run) state_d = IDLE;
            end
            REQUEST: begin
                mic_en  = 1'b1;
                state_d = WAIT_DATA;
            end
            WAIT_DATA: begin
                // run is only looked at once the conversion has finished one way or the other
                if (mic_read_data) begin
                    push_try = 1'b1;
                    state_d  = run ? WAIT_TICK : IDLE;
                end else if (wait_q == 10'(TIMEOUT - 1)) begin
                    timeout_hit = 1'b1;
                    state_d     = run ? WAIT_TICK : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // count never exceeds DEPTH, so its top bit alone marks a full FIFO
    assign full     = count[DEPTH_LOG2];
    assign pop      = m.m_valid && m.m_ready;
    assign push     = push_try && (!full || pop);
    assign overflow = push_try && full && !pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            timer_q <= '0;
            wait_q  <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            status  <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= (!run || tick) ? 16'd0 : timer_q + 16'd1;
            if (state_q == REQUEST)        wait_q <= '0;
            else if (state_q == WAIT_DATA) wait_q <= wait_q + 10'd1;
            if (push) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            if (pop)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
            case ({push, pop})
                2'b10:   count <= count + (DEPTH_LOG2 + 1)'(1);
                2'b01:   count <= count - (DEPTH_LOG2 + 1)'(1);
                default: count <= count;
            endcase
            // a flag raised in the same cycle as clear_status survives the clear
            status <= (status & ~{3{clear_status}}) | {missed_tick, timeout_hit, overflow};
        end
    end

    always_ff @(posedge clk) begin
        if (push && !reset) mem[wr_ptr] <= mic_data;
    end

    assign m.m_data  = mem[rd_ptr];
    assign m.m_valid = (count != '0);
    assign dbg_state = state_q;
endmodule

// File: tb/tb_mic_sample_fifo.sv
// Bench for mic_sample_fifo: a reactive mic reader plus a queue model of the FIFO and its flags.
module tb_mic_sample_fifo;
  localparam int CLK_DIV    = 8;
  localparam int TIMEOUT    = 20;
  localparam int DEPTH_LOG2 = 2;
  localparam int DEPTH      = 1 << DEPTH_LOG2;

  logic                clk = 1'b0;
  logic                reset;
  logic                run;
  logic                mic_en;
  logic [11:0]         mic_data;
  logic                mic_read_data;
  logic [DEPTH_LOG2:0] count;
  logic [2:0]          status;
  logic                clear_status;
  logic [1:0]          dbg_state;

  mic_sample_fifo_if bus ();

  mic_sample_fifo #(.CLK_DIV(CLK_DIV), .TIMEOUT(TIMEOUT), .DEPTH_LOG2(DEPTH_LOG2)) dut (
    .clk(clk), .reset(reset), .run(run), .mic_en(mic_en), .mic_data(mic_data),
    .mic_read_data(mic_read_data), .m(bus), .count(count), .status(status),
    .clear_status(clear_status), .dbg_state(dbg_state)
  );

  // clock / reset bookkeeping
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_rst = -1;

  // reader model state
  int          reader_on = 0;
  int          reader_delay = 5;
  int          rd_busy = 0;
  int          rd_left = 0;
  int          rd_start = 0;
  logic [11:0] rd_val = '0;
  logic        strobe_valid;
  logic [11:0] data_q[$];
  int          en_q[$];

  // scoreboard: expected FIFO contents and expected overflow flag
  logic [11:0] exp_q[$];
  logic        m_ovf = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      last_rst <= cyc + 1;
      exp_q.delete();
      m_ovf <= 1'b0;
    end else begin
      if (exp_q.size() != 0 && bus.m_ready) void'(exp_q.pop_front());
      m_ovf <= (m_ovf && !clear_status) || (mic_read_data && strobe_valid && exp_q.size() >= DEPTH);
      if (mic_read_data && strobe_valid && exp_q.size() < DEPTH) exp_q.push_back(mic_data);
    end
  end

  // mic reader: answers reader_delay clocks after each mic_en
  initial begin
    mic_read_data = 1'b0;
    mic_data = '0;
    strobe_valid = 1'b0;
    forever begin
      @(negedge clk);
      mic_read_data = 1'b0;
      strobe_valid = 1'b0;
      if (rd_busy != 0) begin
        rd_left--;
        if (rd_left == 0) begin
          mic_read_data = 1'b1;
          mic_data = rd_val;
          strobe_valid = (rd_start > last_rst);
          rd_busy = 0;
        end
      end
      if (mic_en) begin
        en_q.push_back(cyc);
        if (reader_on != 0 && rd_busy == 0) begin
          rd_busy = 1;
          rd_left = reader_delay;
          rd_start = cyc;
          rd_val = (data_q.size() != 0) ? data_q.pop_front() : 12'($urandom);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_fifo(input string tag);
    chk({tag, ".count"}, 32'(count), 32'(exp_q.size()));
    chk({tag, ".valid"}, 32'(bus.m_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) chk({tag, ".data"}, 32'(bus.m_data), 32'(exp_q[0]));
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic wait_en(input int n, input string tag);
    int guard = 0;
    while (en_q.size() < n && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    chk(tag, 32'(en_q.size() >= n), 32'd1);
  endtask

  function automatic int en_at(input int i);
    if (i >= 0 && i < en_q.size()) return en_q[i];
    return -1000;
  endfunction

  // gap between requests when a conversion occupies 'busy' clocks after mic_en
  function automatic int exp_gap(input int busy);
    int g = CLK_DIV;
    while (g - 1 < busy + 1) g += CLK_DIV;
    return g;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    run = 1'b0;
    clear_status = 1'b0;
    bus.m_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int base, r0, c1, c2, c5;

    // reset state
    do_reset();
    chk("rst.count", 32'(count), 32'd0);
    chk("rst.valid", 32'(bus.m_valid), 32'd0);
    chk("rst.status", 32'(status), 32'd0);
    chk("rst.mic_en", 32'(mic_en), 32'd0);

    // two samples in order, fixed request period
    reader_on = 1;
    reader_delay = 5;
    data_q.push_back(12'h123);
    data_q.push_back(12'h456);
    base = en_q.size();
    r0 = cyc;
    run = 1'b1;
    wait_en(base + 1, "r35.en1");
    c1 = en_at(base);
    chk("r35.first_en", 32'(c1 - r0), 32'(CLK_DIV));
    wait_cyc(c1 + 5);
    chk("r35.pre_push_count", 32'(count), 32'd0);
    wait_cyc(c1 + 6);
    chk("r35.count1", 32'(count), 32'd1);
    chk("r35.data1", 32'(bus.m_data), 32'h123);
    check_fifo("r35.a");
    wait_en(base + 2, "r35.en2");
    c2 = en_at(base + 1);
    chk("r35.gap", 32'(c2 - c1), 32'(exp_gap(5)));
    wait_cyc(c2 + 6);
    chk("r35.count2", 32'(count), 32'd2);
    chk("r35.hold", 32'(bus.m_data), 32'h123);
    bus.m_ready = 1'b1;
    @(negedge clk);
    bus.m_ready = 1'b0;
    run = 1'b0;
    chk("r35.data2", 32'(bus.m_data), 32'h456);
    check_fifo("r35.b");

    // overflow when the consumer stalls
    do_reset();
    base = en_q.size();
    run = 1'b1;
    wait_en(base + 5, "r36.en5");
    c5 = en_at(base + 4);
    wait_cyc(c5 + 6);
    run = 1'b0;
    chk("r36.count", 32'(count), 32'd4);
    chk("r36.status", 32'(status), 32'b001);
    check_fifo("r36.full");
    bus.m_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_fifo("r36.drain");
    end
    chk("r36.empty", 32'(count), 32'd0);

    // silent reader: timeout, missed ticks, set-wins clear
    do_reset();
    reader_on = 0;
    base = en_q.size();
    run = 1'b1;
    wait_en(base + 1, "r37.en1");
    c1 = en_at(base);
    wait_cyc(c1 + TIMEOUT);
    chk("r37.before", 32'(status), 32'b100);
    clear_status = 1'b1;
    wait_cyc(c1 + TIMEOUT + 1);
    clear_status = 1'b0;
    chk("r37.after", 32'(status), 32'b010);
    chk("r37.count", 32'(count), 32'd0);
    wait_en(base + 2, "r37.en2");
    chk("r37.gap", 32'(en_at(base + 1) - c1), 32'(exp_gap(TIMEOUT)));

    // slow reader: missed tick, then clear
    do_reset();
    reader_on = 1;
    reader_delay = 12;
    base = en_q.size();
    run = 1'b1;
    wait_en(base + 2, "r38.en2");
    run = 1'b0;
    chk("r38.gap", 32'(en_at(base + 1) - en_at(base)), 32'(exp_gap(12)));
    repeat (20) @(negedge clk);
    chk("r38.status", 32'(status), 32'b100);
    check_fifo("r38.fifo");
    clear_status = 1'b1;
    @(negedge clk);
    clear_status = 1'b0;
    chk("r38.cleared", 32'(status), 32'b000);

    // full FIFO with push and pop in the same cycle
    do_reset();
    reader_delay = 5;
    base = en_q.size();
    run = 1'b1;
    wait_en(base + 5, "r39.en5");
    c5 = en_at(base + 4);
    wait_cyc(c5 + 5);
    bus.m_ready = 1'b1;
    wait_cyc(c5 + 6);
    bus.m_ready = 1'b0;
    run = 1'b0;
    chk("r39.count", 32'(count), 32'd4);
    chk("r39.status", 32'(status), 32'b000);
    check_fifo("r39.full");
    bus.m_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_fifo("r39.drain");
    end

    // reset during a conversion discards it
    do_reset();
    base = en_q.size();
    run = 1'b1;
    wait_en(base + 1, "r40.en1");
    wait_cyc(en_at(base) + 6);
    chk("r40.count1", 32'(count), 32'd1);
    wait_en(base + 2, "r40.en2");
    c2 = en_at(base + 1);
    wait_cyc(c2 + 2);
    reset = 1'b1;
    run = 1'b0;
    wait_cyc(c2 + 3);
    reset = 1'b0;
    wait_cyc(c2 + 7);
    chk("r40.count", 32'(count), 32'd0);
    chk("r40.valid", 32'(bus.m_valid), 32'd0);
    chk("r40.status", 32'(status), 32'd0);
    check_fifo("r40.fifo");

    // random consumer and reader latency
    do_reset();
    base = en_q.size();
    run = 1'b1;
    for (int i = 0; i < 240; i++) begin
      reader_delay = $urandom_range(3, 6);
      bus.m_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      check_fifo("rnd");
      chk("rnd.status", 32'(status), 32'({2'b00, m_ovf}));
    end
    run = 1'b0;
    bus.m_ready = 1'b0;
    for (int i = base + 1; i < en_q.size(); i++)
      chk("rnd.gap", 32'(en_q[i] - en_q[i - 1]), 32'(exp_gap(6)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
